// File: rtl/multi_clock_divider.sv
// Runtime-programmable multi-channel clock divider with a valid/ready divisor port.
// Optional `define CLKDIV_SYNC_EN adds a sync input that phase-aligns all channels.
module multi_clock_divider #(
    parameter int          NUM_CH      = 4,
    parameter int          COUNT_WIDTH = 24,
    parameter int unsigned DEFAULT_MAX = 6000000 - 1,
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef CLKDIV_SYNC_EN
    input  logic                   sync,
`endif
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CH_W-1:0]        cfg_ch,
    input  logic [COUNT_WIDTH-1:0] cfg_max,
    input  logic                   cfg_en,
    output logic [NUM_CH-1:0]      out,
    output logic [NUM_CH-1:0]      tick
);

    localparam logic [COUNT_WIDTH-1:0] DEF_MAX = COUNT_WIDTH'(DEFAULT_MAX);

    logic [COUNT_WIDTH-1:0] count      [NUM_CH];
    logic [COUNT_WIDTH-1:0] max_active [NUM_CH];
    logic [COUNT_WIDTH-1:0] max_shadow [NUM_CH];
    logic [NUM_CH-1:0]      pending;
    logic [NUM_CH-1:0]      en;
    logic [NUM_CH-1:0]      wr_sel;
    logic                   ch_valid;
    logic                   accept;
    logic                   sync_w;

`ifdef CLKDIV_SYNC_EN
    assign sync_w = sync;
`else
    assign sync_w = 1'b0;
`endif

    // Out-of-range channels always look ready so a stray write never stalls the port.
    assign ch_valid  = (32'(cfg_ch) < NUM_CH);
    assign cfg_ready = ch_valid ? ~pending[cfg_ch] : 1'b1;
    assign accept    = cfg_valid && cfg_ready && ch_valid;

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = accept && (32'(cfg_ch) == i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count[i]      <= '0;
                max_active[i] <= DEF_MAX;
                max_shadow[i] <= DEF_MAX;
            end
            out     <= '0;
            tick    <= '0;
            pending <= '0;
            en      <= '1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (en[i]) begin
                    if (wr_sel[i] && !cfg_en) begin
                        en[i]         <= 1'b0;
                        count[i]      <= '0;
                        out[i]        <= 1'b0;
                        tick[i]       <= 1'b0;
                        max_active[i] <= cfg_max;
                        pending[i]    <= 1'b0;
                    end else begin
                        if (sync_w) begin
                            count[i] <= '0;
                            out[i]   <= 1'b0;
                            tick[i]  <= 1'b0;
                            if (pending[i]) begin
                                max_active[i] <= max_shadow[i];
                                pending[i]    <= 1'b0;
                            end
                        end else if (count[i] == max_active[i]) begin
                            count[i] <= '0;
                            out[i]   <= ~out[i];
                            tick[i]  <= 1'b1;
                            if (pending[i]) begin
                                max_active[i] <= max_shadow[i];
                                pending[i]    <= 1'b0;
                            end
                        end else begin
                            count[i] <= count[i] + COUNT_WIDTH'(1);
                            tick[i]  <= 1'b0;
                        end
                        // Only reachable with pending clear, so this never races the apply above.
                        if (wr_sel[i]) begin
                            max_shadow[i] <= cfg_max;
                            pending[i]    <= 1'b1;
                        end
                    end
                end else begin
                    count[i] <= '0;
                    out[i]   <= 1'b0;
                    tick[i]  <= 1'b0;
                    if (wr_sel[i]) begin
                        max_active[i] <= cfg_max;
                        en[i]         <= cfg_en;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Scoreboard bench for multi_clock_divider: a remaining-cycles model predicts out/tick/cfg_ready.
module tb_multi_clock_divider;

    localparam int NCH  = 2;
    localparam int CW   = 8;
    localparam int DMAX = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [0:0]    cfg_ch = '0;
    logic [CW-1:0] cfg_max = '0;
    logic          cfg_en = 1'b0;
    logic [NCH-1:0] out;
    logic [NCH-1:0] tick;
    logic          sync_i = 1'b0;

    always #5 clk = ~clk;

    multi_clock_divider #(
        .NUM_CH(NCH),
        .COUNT_WIDTH(CW),
        .DEFAULT_MAX(DMAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef CLKDIV_SYNC_EN
        .sync(sync_i),
`endif
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_max(cfg_max),
        .cfg_en(cfg_en),
        .out(out),
        .tick(tick)
    );

    typedef struct packed {
        logic [NCH-1:0] o;
        logic [NCH-1:0] t;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    int            m_rem    [NCH];
    logic [CW-1:0] m_max    [NCH];
    logic [CW-1:0] m_shadow [NCH];
    logic [NCH-1:0] m_pend, m_en, m_out, m_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_rem[i]    = DMAX;
            m_max[i]    = CW'(DMAX);
            m_shadow[i] = CW'(DMAX);
        end
        m_pend = '0;
        m_en   = '1;
        m_out  = '0;
        m_tick = '0;
    endtask

    function automatic logic model_ready(input logic [0:0] c);
        if (int'(c) >= NCH) return 1'b1;
        return ~m_pend[c];
    endfunction

    task automatic model_step(input logic v, input logic [0:0] c, input logic [CW-1:0] mx,
                              input logic e, input logic s);
        logic acc;
        logic wr;
        acc = v && model_ready(c) && (int'(c) < NCH);
        for (int i = 0; i < NCH; i++) begin
            wr = acc && (int'(c) == i);
            if (!m_en[i]) begin
                m_out[i]  = 1'b0;
                m_tick[i] = 1'b0;
                if (wr) begin
                    m_max[i] = mx;
                    m_en[i]  = e;
                    m_rem[i] = int'(mx);
                end
            end else if (wr && !e) begin
                m_en[i]   = 1'b0;
                m_out[i]  = 1'b0;
                m_tick[i] = 1'b0;
                m_max[i]  = mx;
                m_pend[i] = 1'b0;
            end else begin
                if (s) begin
                    m_out[i]  = 1'b0;
                    m_tick[i] = 1'b0;
                    if (m_pend[i]) begin m_max[i] = m_shadow[i]; m_pend[i] = 1'b0; end
                    m_rem[i] = int'(m_max[i]);
                end else if (m_rem[i] == 0) begin
                    m_out[i]  = ~m_out[i];
                    m_tick[i] = 1'b1;
                    if (m_pend[i]) begin m_max[i] = m_shadow[i]; m_pend[i] = 1'b0; end
                    m_rem[i] = int'(m_max[i]);
                end else begin
                    m_rem[i]  = m_rem[i] - 1;
                    m_tick[i] = 1'b0;
                end
                if (wr) begin
                    m_shadow[i] = mx;
                    m_pend[i]   = 1'b1;
                end
            end
        end
        exp_q.push_back('{o: m_out, t: m_tick});
    endtask

    // Called at posedge+1; checks ready at the negedge, outputs at the next posedge+1.
    task automatic cycle(input logic v, input logic [0:0] c, input logic [CW-1:0] mx,
                         input logic e, input logic s);
        exp_t ex;
        cfg_valid = v;
        cfg_ch    = c;
        cfg_max   = mx;
        cfg_en    = e;
        sync_i    = s;
        #4;
        chk("cfg_ready", 32'(cfg_ready), 32'(model_ready(c)));
        model_step(v, c, mx, e, s);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'(0), 32'(1));
        end else begin
            ex = exp_q.pop_front();
            chk("out", 32'(out), 32'(ex.o));
            chk("tick", 32'(tick), 32'(ex.t));
        end
        cfg_valid = 1'b0;
        sync_i    = 1'b0;
    endtask

    task automatic idle(input int n, input logic [0:0] c);
        for (int k = 0; k < n; k++) cycle(1'b0, c, '0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out", 32'(out), 32'(0));
        chk("rst_tick", 32'(tick), 32'(0));
        #1;
        chk("rst_ready", 32'(cfg_ready), 32'(1));
        @(posedge clk);
        #1;
        // that edge was edge 1 after release
        model_step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        chk("edge1_out", 32'(out), 32'(0));

        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'd1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 8'd2, 1'b1, 1'b0);
        chk("edge4_out", 32'(out), 32'(2'b11));
        chk("edge4_tick", 32'(tick), 32'(2'b11));
        idle(12, 1'b1);

        cycle(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
        idle(10, 1'b0);

        cycle(1'b1, 1'b0, 8'd5, 1'b0, 1'b0);
        chk("dis_out0", 32'(out[0]), 32'(0));
        idle(4, 1'b0);
        cycle(1'b1, 1'b0, 8'd5, 1'b1, 1'b0);
        idle(16, 1'b0);

        // async reset with a pending write on ch1
        cycle(1'b1, 1'b1, 8'd6, 1'b1, 1'b0);
        idle(2, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_out", 32'(out), 32'(0));
        chk("async_tick", 32'(tick), 32'(0));
        chk("async_ready", 32'(cfg_ready), 32'(1));
        model_reset();
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20, 1'b1);

`ifdef CLKDIV_SYNC_EN
        cycle(1'b1, 1'b1, 8'd3, 1'b0, 1'b0);
        idle(1, 1'b1);
        cycle(1'b1, 1'b1, 8'd3, 1'b1, 1'b0);
        idle(3, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("sync_out", 32'(out), 32'(0));
        idle(16, 1'b0);
        cycle(1'b1, 1'b0, 8'd2, 1'b1, 1'b1);
        idle(12, 1'b0);
`endif

        for (int k = 0; k < 300; k++) begin
            logic s;
            s = 1'b0;
`ifdef CLKDIV_SYNC_EN
            s = ($urandom_range(0, 19) == 0);
`endif
            cycle($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)),
                  CW'($urandom_range(0, 7)), $urandom_range(0, 4) != 0, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
